freq_word_ctrl: RTL and testbench

Parametrised, fully synchronous tuning-word controller for the DDS phase accumulator. Six active-low front-panel buttons (add/sub at coarse, mid and fine granularity) are synchronised, debounced and edge-detected. Each press is converted into a single saturating increment or decrement of the frequency step word. The `step` output feeds the phase accumulator directly, and `step_upd` marks every change for downstream display logic.

---
 rtl/freq_word_ctrl.sv | 160 ++++++++++++++++
 tb/tb_freq_word_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/freq_word_ctrl.sv
// rtl/freq_word_ctrl.sv - debounced push-button tuning-word controller for the DDS phase accumulator
// Optional auto-repeat on held buttons: define FREQ_CTRL_AUTOREPEAT_EN.
module freq_word_ctrl #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] INIT_STEP    = WIDTH'(2147483),
    parameter logic [WIDTH-1:0] STEP_COARSE  = WIDTH'(2147483),
    parameter logic [WIDTH-1:0] STEP_MID     = WIDTH'(214748),
    parameter logic [WIDTH-1:0] STEP_FINE    = WIDTH'(214),
    parameter logic [WIDTH-1:0] STEP_MIN     = '0,
    parameter logic [WIDTH-1:0] STEP_MAX     = {WIDTH{1'b1}},
    parameter int               DB_CYCLES    = 50000,
    parameter int               REPEAT_DELAY = 25000000,
    parameter int               REPEAT_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       btn_add,
    input  logic [2:0]       btn_sub,
    output logic [WIDTH-1:0] step,
    output logic             step_upd,
    output logic             at_limit
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    // Bits [2:0] are the add buttons, [5:3] the sub buttons; all active-low.
    logic [5:0]     btn_raw;
    logic [5:0]     sync1;
    logic [5:0]     sync2;
    logic [5:0]     db;
    logic [5:0]     db_d;
    logic [5:0]     press;
    logic [5:0]     evt;
    logic [DBW-1:0] db_cnt [6];

    assign btn_raw = {btn_sub, btn_add};
    assign press   = db_d & ~db;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            db_d  <= '1;
            for (int i = 0; i < 6; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef FREQ_CTRL_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] hold_cnt [6];
    logic [5:0]    rep_phase;
    logic [5:0]    rep_fire;

    // hold_cnt counts cycles since the last press/repeat event of that button.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 6; i++) begin
            rep_fire[i] = ~db[i] & ~press[i] &
                          (hold_cnt[i] == (rep_phase[i] ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_phase <= '0;
            for (int i = 0; i < 6; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (db[i]) begin
                    hold_cnt[i]  <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (press[i]) begin
                    hold_cnt[i]  <= RW'(1);
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    hold_cnt[i]  <= RW'(1);
                    rep_phase[i] <= 1'b1;
                end else begin
                    hold_cnt[i]  <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign evt = press | rep_fire;
`else
    assign evt = press;
`endif

    logic             apply;
    logic             is_add;
    logic [WIDTH-1:0] delta;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   floor_lim;
    logic [WIDTH-1:0] next_step;

    // Winning granularity decides; coincident add+sub there cancels and blocks lower ones.
    always_comb begin
        apply  = 1'b0;
        is_add = 1'b0;
        delta  = '0;
        if (evt[2] | evt[5]) begin
            apply  = evt[2] ^ evt[5];
            is_add = evt[2];
            delta  = STEP_COARSE;
        end else if (evt[1] | evt[4]) begin
            apply  = evt[1] ^ evt[4];
            is_add = evt[1];
            delta  = STEP_MID;
        end else if (evt[0] | evt[3]) begin
            apply  = evt[0] ^ evt[3];
            is_add = evt[0];
            delta  = STEP_FINE;
        end
        sum       = {1'b0, step} + {1'b0, delta};
        floor_lim = {1'b0, STEP_MIN} + {1'b0, delta};
        if (is_add) begin
            next_step = (sum > {1'b0, STEP_MAX}) ? STEP_MAX : sum[WIDTH-1:0];
        end else begin
            next_step = ({1'b0, step} < floor_lim) ? STEP_MIN : step - delta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step     <= INIT_STEP;
            step_upd <= 1'b0;
        end else if (apply) begin
            step     <= next_step;
            step_upd <= (next_step != step);
        end else begin
            step_upd <= 1'b0;
        end
    end

    assign at_limit = (step == STEP_MIN) || (step == STEP_MAX);

endmodule

// File: tb/tb_freq_word_ctrl.sv
// tb/tb_freq_word_ctrl.sv - scoreboard bench for freq_word_ctrl with directed button vectors
module tb_freq_word_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  btn_add = 3'b111;
    logic [2:0]  btn_sub = 3'b111;
    logic [15:0] step;
    logic        step_upd;
    logic        at_limit;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        int cyc;
        int val;
        bit lim;
    } exp_t;

    exp_t exp_q[$];

    freq_word_ctrl #(
        .WIDTH(16), .INIT_STEP(16'd1000), .STEP_COARSE(16'd100), .STEP_MID(16'd10),
        .STEP_FINE(16'd1), .STEP_MIN(16'd0), .STEP_MAX(16'd1050), .DB_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_RATE(8)
    ) dut (
        .clk(clk), .reset(reset), .btn_add(btn_add), .btn_sub(btn_sub),
        .step(step), .step_upd(step_upd), .at_limit(at_limit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every step_upd pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && step_upd) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_upd", int'(step), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("upd_cycle", cyc, e.cyc);
                chk("upd_value", int'(step), e.val);
                chk("upd_limit", int'(at_limit), int'(e.lim));
            end
        end
    end

    // Press buttons a/s (active-high masks) for hold cycles, then release and settle.
    // A fall just before edge k updates step at edge k+6 with DB_CYCLES=4.
    task automatic tap(input logic [2:0] a, input logic [2:0] s, input int hold,
                       input bit upd, input int val, input bit lim);
        @(negedge clk);
        if (upd) exp_q.push_back('{cyc + 7, val, lim});
        btn_add = ~a;
        btn_sub = ~s;
        repeat (hold) @(negedge clk);
        btn_add = 3'b111;
        btn_sub = 3'b111;
        repeat (10) @(negedge clk);
        chk("step_after_tap", int'(step), val);
        chk("limit_after_tap", int'(at_limit), int'(lim));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_step", int'(step), 1000);
        chk("reset_upd", int'(step_upd), 0);
        chk("reset_limit", int'(at_limit), 0);
        repeat (10) @(negedge clk);
        chk("idle_step", int'(step), 1000);

        // Bounce rejection, then a clean press with exact latency.
        btn_add[0] = 1'b0;
        repeat (2) @(negedge clk);
        btn_add[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("bounce_step", int'(step), 1000);
        btn_add[0] = 1'b0;
        exp_q.push_back('{cyc + 7, 1001, 1'b0});
        repeat (12) @(negedge clk);
        btn_add[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("fine_add_step", int'(step), 1001);

        // Upper saturation.
        tap(3'b100, 3'b000, 8, 1'b1, 1050, 1'b1);
        tap(3'b100, 3'b000, 8, 1'b0, 1050, 1'b1);

        // Simultaneous presses.
        tap(3'b000, 3'b100, 8, 1'b1, 950, 1'b0);
        tap(3'b010, 3'b010, 8, 1'b0, 950, 1'b0);
        tap(3'b100, 3'b001, 8, 1'b1, 1050, 1'b1);

        // Walk down to 5, then hit the lower bound.
        for (int i = 1; i <= 10; i++) tap(3'b000, 3'b100, 8, 1'b1, 1050 - 100 * i, 1'b0);
        for (int i = 1; i <= 4; i++)  tap(3'b000, 3'b010, 8, 1'b1, 50 - 10 * i, 1'b0);
        for (int i = 1; i <= 5; i++)  tap(3'b000, 3'b001, 8, 1'b1, 10 - i, 1'b0);
        tap(3'b000, 3'b010, 8, 1'b1, 0, 1'b1);
        tap(3'b000, 3'b001, 8, 1'b0, 0, 1'b1);
        tap(3'b001, 3'b000, 8, 1'b1, 1, 1'b0);

`ifdef FREQ_CTRL_AUTOREPEAT_EN
        // Hold fine add: press plus repeats at +20, +28, +36 cycles after the press update.
        @(negedge clk);
        c = cyc;
        btn_add[0] = 1'b0;
        exp_q.push_back('{c + 7, 2, 1'b0});
        exp_q.push_back('{c + 27, 3, 1'b0});
        exp_q.push_back('{c + 35, 4, 1'b0});
        exp_q.push_back('{c + 43, 5, 1'b0});
        repeat (46) @(negedge clk);
        chk("repeat_step", int'(step), 5);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold_reset_step", int'(step), 1000);
        chk("hold_reset_upd", int'(step_upd), 0);
        reset = 1'b0;
        exp_q.push_back('{cyc + 7, 1001, 1'b0});
        repeat (12) @(negedge clk);
        btn_add[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_press", int'(step), 1001);
`else
        c = 0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
